rshift_scheduler: RTL and testbench

//  Round-robin scheduler that shares one arithmetic right-shift datapath between NUM_REQ requesters
//  (e.g. attention heads). A job is a burst of BEATS vectors; the scheduler grants a job, latches
//  its shift amount, steers beat valid/ready, counts datapath returns and tags them.
//  It sits between the head-level requesters and the shared shift unit in the self-attention head.

---
 rtl/rshift_scheduler.sv | 119 +++++++++++
 tb/tb_rshift_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rshift_scheduler.sv
// rtl/rshift_scheduler.sv - round-robin job scheduler for the shared arithmetic right-shift datapath
// Grants one requester a burst of BEATS vectors, steers beat handshakes and tags datapath returns.
module rshift_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int BEATS     = 2,
  parameter int SHAMT_W   = 4,
  parameter int SHIFT_LAT = 1,
  parameter int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  output logic [NUM_REQ-1:0]         grant,
  input  logic [NUM_REQ-1:0]         beat_valid,
  output logic [NUM_REQ-1:0]         beat_ready,
  output logic                       dp_in_valid,
  output logic [SHAMT_W-1:0]         dp_shamt,
  input  logic                       dp_out_valid,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       err
);

  localparam int CW = $clog2(BEATS + 1);
  localparam int PW = TAG_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STREAM, S_DRAIN} state_t;

  state_t          state;
  logic [TAG_W-1:0] win_idx;
  logic [TAG_W-1:0] rr_ptr;
  logic [CW-1:0]    iss_cnt;
  logic [CW-1:0]    ret_cnt;

  logic             arb_found;
  logic [TAG_W-1:0] arb_idx;
  logic [TAG_W-1:0] rr_next;
  logic [PW-1:0]    cand;
  logic [CW-1:0]    issued_now;
  logic             ret_ok;
  logic             ret_acc;

  // First requester at or after rr_ptr, wrapping around NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + PW'(i);
      if (cand >= PW'(NUM_REQ)) cand = cand - PW'(NUM_REQ);
      if (!arb_found && req[cand[TAG_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[TAG_W-1:0];
      end
    end
  end

  assign rr_next = (arb_idx == TAG_W'(NUM_REQ - 1)) ? '0 : arb_idx + TAG_W'(1);

  assign beat_ready  = (state == S_STREAM) ? grant : '0;
  assign dp_in_valid = |(beat_valid & beat_ready);

  // A zero-latency datapath can return a beat in the same cycle it is issued.
  assign issued_now = iss_cnt + ((SHIFT_LAT == 0) ? CW'(dp_in_valid) : CW'(0));
  assign ret_ok     = ((state == S_STREAM) || (state == S_DRAIN)) && (ret_cnt < issued_now);
  assign ret_acc    = dp_out_valid && ret_ok;

  assign out_valid = ret_acc;
  assign out_tag   = win_idx;
  assign out_last  = ret_acc && (ret_cnt == CW'(BEATS - 1));
  assign done      = out_last ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      dp_shamt <= '0;
      win_idx  <= '0;
      rr_ptr   <= '0;
      iss_cnt  <= '0;
      ret_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (dp_out_valid && !ret_ok) err <= 1'b1;
      case (state)
        S_IDLE: begin
          iss_cnt <= '0;
          ret_cnt <= '0;
          if (arb_found) begin
            win_idx  <= arb_idx;
            dp_shamt <= req_shamt[arb_idx*SHAMT_W +: SHAMT_W];
            rr_ptr   <= rr_next;
            grant    <= NUM_REQ'(1) << arb_idx;
            state    <= S_GRANT;
          end
        end
        S_GRANT: state <= S_STREAM;
        S_STREAM, S_DRAIN: begin
          if (dp_in_valid) iss_cnt <= iss_cnt + CW'(1);
          if (ret_acc) ret_cnt <= ret_cnt + CW'(1);
          // Grant is held through the done cycle and clears on this edge.
          if (out_last) begin
            grant <= '0;
            state <= S_IDLE;
          end else if (state == S_STREAM && dp_in_valid && iss_cnt == CW'(BEATS - 1)) begin
            state <= S_DRAIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rshift_scheduler.sv
// tb/tb_rshift_scheduler.sv - scoreboard bench for rshift_scheduler
// Job-level round-robin model feeds an expectation queue; a monitor checks every result beat.
module tb_rshift_scheduler;

  localparam int N = 4;
  localparam int BEATS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*4-1:0] req_shamt;
  logic [N-1:0]  grant;
  logic [N-1:0]  beat_valid;
  logic [N-1:0]  beat_ready;
  logic          dp_in_valid;
  logic [3:0]    dp_shamt;
  wire           dp_out_valid;
  logic [1:0]    out_tag;
  logic          out_valid;
  logic          out_last;
  logic [N-1:0]  done;
  logic          busy;
  logic          err;

  logic dp_model, dp_pipe, dp_inject;
  assign dp_out_valid = (dp_model & ~rst) | dp_inject;

  rshift_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_shamt(req_shamt), .grant(grant),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .dp_in_valid(dp_in_valid),
    .dp_shamt(dp_shamt), .dp_out_valid(dp_out_valid), .out_tag(out_tag),
    .out_valid(out_valid), .out_last(out_last), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       tag;
    bit       last;
    logic [3:0] shamt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_ptr = 0;
  int   cyc_n = 0;
  int   last_done = -1;
  bit   gap_chk = 1'b0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    int c;
    for (int i = 0; i < N; i++) begin
      c = (m_ptr + i) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  // Datapath stand-in: one cycle of latency, cleared by the shared reset.
  initial begin
    dp_model = 1'b0;
    dp_pipe  = 1'b0;
    forever begin
      @(negedge clk);
      dp_pipe = dp_in_valid & ~rst;
      @(posedge clk);
      #1;
      dp_model = dp_pipe;
    end
  end

  // Monitor: pops one expectation per result beat.
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst) begin
        chk("ready_only_granted", 32'(beat_ready & ~grant), 32'd0);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.tag;
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("dp_shamt", 32'(dp_shamt), 32'(e.shamt));
            chk("done_on_beat", 32'(done), e.last ? 32'(oh) : 32'd0);
          end
        end else begin
          chk("done_idle", 32'(done), 32'd0);
        end
        if (grant != '0 && prev_grant == '0 && gap_chk && last_done >= 0)
          chk("done_to_grant_gap", 32'(cyc_n - last_done), 32'd2);
        if (done != '0) last_done = cyc_n;
        prev_grant = grant;
      end else begin
        prev_grant = '0;
      end
    end
  end

  // mode 0: granted beat_valid held, 1: pattern 1,0,0,1, 2: random.
  task automatic do_job(input logic [N-1:0] r, input int mode, input bit keep, input int force_sh);
    int w, cyc, acc, k;
    bit fin, b;
    logic [3:0] sh;
    logic [N-1:0] oh, bv;
    w = model_pick(r);
    m_ptr = (w + 1) % N;
    oh = 4'b0001 << w;
    req_shamt = 16'($urandom);
    if (force_sh >= 0) req_shamt[w*4 +: 4] = 4'(force_sh);
    sh = req_shamt[w*4 +: 4];
    for (int i = 0; i < BEATS; i++) exp_q.push_back('{tag: w, last: (i == BEATS - 1), shamt: sh});
    req = r;
    cyc = 0;
    @(negedge clk);
    while (grant == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", 32'(grant), 32'(oh));
    if (grant == '0) begin
      exp_q.delete();
      return;
    end
    acc = 0; fin = 1'b0; k = 0;
    while (!fin && k < 40) begin
      @(posedge clk);
      #1;
      if (!keep) req = '0;
      req_shamt = 16'($urandom);
      bv = 4'($urandom);
      case (mode)
        0:       b = 1'b1;
        1:       b = (k % 4 == 0) || (k % 4 == 3);
        default: b = 1'($urandom_range(0, 1));
      endcase
      bv[w[1:0]] = b;
      beat_valid = bv;
      @(negedge clk);
      chk("beat_ready", 32'(beat_ready), (acc < BEATS) ? 32'(oh) : 32'd0);
      if (dp_in_valid) acc++;
      if (done != '0) begin
        chk("done_owner", 32'(done), 32'(oh));
        fin = 1'b1;
      end
      k++;
    end
    beat_valid = '0;
    chk("dp_in_pulses", 32'(acc), 32'(BEATS));
    chk("job_completed", 32'(fin), 32'd1);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [N-1:0] r;
    rst = 1'b1; req = 4'b1111; beat_valid = '0; dp_inject = 1'b0; req_shamt = '0;

    // Reset with every requester asking.
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_beat_ready", 32'(beat_ready), 32'd0);
    chk("rst_dp_in_valid", 32'(dp_in_valid), 32'd0);
    chk("rst_dp_shamt", 32'(dp_shamt), 32'd0);
    chk("rst_out", 32'({out_valid, out_last, done, busy, err}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", 32'({grant, busy}), 32'd0);
    do_job(4'b1111, 0, 1'b0, -1);

    // Single job on requester 2 with shamt 3.
    do_job(4'b0100, 0, 1'b0, 3);

    // Round-robin with requests held: 0,1,2,3,0.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0;
    last_done = -1;
    gap_chk = 1'b1;
    for (int j = 0; j < 5; j++) do_job(4'b1111, 2, 1'b1, -1);
    gap_chk = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);

    // Backpressure on requester 1 (next after 0).
    do_job(4'b0010, 1, 1'b0, -1);

    // Stray return while idle.
    @(posedge clk);
    #1 dp_inject = 1'b1;
    @(negedge clk);
    chk("err_no_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 dp_inject = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    do_job(4'b1000, 2, 1'b0, -1);
    chk("err_sticky", 32'(err), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);

    // Reset after one accepted beat.
    req = 4'b0100;
    void'(model_pick(req));
    @(negedge clk);
    for (int t = 0; t < 10 && grant == '0; t++) @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'b0100);
    @(posedge clk);
    #1 req = '0; beat_valid = 4'b0100;
    @(negedge clk);
    chk("midrst_accept", 32'(dp_in_valid), 32'd1);
    @(posedge clk);
    #1 beat_valid = '0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_idle", 32'({grant, busy}), 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    do_job(4'b0100, 0, 1'b0, -1);

    // Random jobs.
    for (int j = 0; j < 10; j++) begin
      r = 4'($urandom_range(1, 15));
      do_job(r, 2, 1'($urandom_range(0, 1)), -1);
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("final_idle", 32'({busy, grant}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
